// File: rtl/tdm_mux.sv
// Registered CH:1 multiplexer with manual select and dwell-timed round-robin auto-scan.
// Optional build macro TDM_MUX_SKIP_MASK_EN adds ch_mask so auto-scan skips excluded channels.
module tdm_mux #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int DWELL = 4,
    localparam int SELW = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH*WIDTH-1:0]   din,
    input  logic [SELW-1:0]       sel,
    input  logic                  mode,
    input  logic                  en,
`ifdef TDM_MUX_SKIP_MASK_EN
    input  logic [CH-1:0]         ch_mask,
`endif
    output logic [WIDTH-1:0]      y,
    output logic                  y_valid,
    output logic [SELW-1:0]       ch_id
);

    localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [SELW-1:0]   ptr, ptr_n;
    logic [CNTW-1:0]   dwell, dwell_n;
    logic [WIDTH-1:0]  y_n;
    logic [SELW-1:0]   ch_n;
    logic              valid_n;
    logic              sel_ok;
    logic [SELW-1:0]   start_ch;
    logic [SELW-1:0]   scan_ch;

    function automatic logic [WIDTH-1:0] pick(input logic [CH*WIDTH-1:0] d,
                                              input logic [SELW-1:0] idx);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < CH; k++)
            if (idx == SELW'(k)) r = d[k*WIDTH +: WIDTH];
        return r;
    endfunction

    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] p);
        return (p == SELW'(CH-1)) ? '0 : p + SELW'(1);
    endfunction

`ifdef TDM_MUX_SKIP_MASK_EN
    // Lowest set mask bit at or above start, else lowest set bit overall (wrap).
    function automatic logic [SELW-1:0] first_set(input logic [SELW-1:0] start,
                                                  input logic [CH-1:0] m);
        logic [SELW-1:0] hi, lo;
        logic            hi_ok, lo_ok;
        hi = start; lo = start; hi_ok = 1'b0; lo_ok = 1'b0;
        for (int unsigned k = 0; k < CH; k++) begin
            if (m[k] && !lo_ok) begin lo = SELW'(k); lo_ok = 1'b1; end
            if (m[k] && !hi_ok && k >= 32'(start)) begin hi = SELW'(k); hi_ok = 1'b1; end
        end
        return hi_ok ? hi : lo;
    endfunction
`endif

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        dwell_n  = dwell;
        y_n      = y;
        ch_n     = ch_id;
        valid_n  = 1'b0;
        sel_ok   = (int'(sel) < CH);
        start_ch = sel_ok ? sel : '0;
        scan_ch  = ptr;
        if (en) begin
            if (!mode) begin
                state_n = MANUAL;
                ch_n    = sel;
                y_n     = sel_ok ? pick(din, sel) : '0;
                valid_n = sel_ok;
            end else if (state == MANUAL) begin
                state_n = SCAN;
                dwell_n = '0;
`ifdef TDM_MUX_SKIP_MASK_EN
                start_ch = first_set(start_ch, ch_mask);
                ptr_n    = start_ch;
                if (|ch_mask) begin
                    y_n     = pick(din, start_ch);
                    ch_n    = start_ch;
                    valid_n = 1'b1;
                end
`else
                ptr_n   = start_ch;
                y_n     = pick(din, start_ch);
                ch_n    = start_ch;
                valid_n = 1'b1;
`endif
            end else begin
                // dwell tracks which cycle of the slot y now shows; the entry edge is slot
                // cycle 0, so on expiry the capture already uses the advanced channel.
                if (dwell == CNTW'(DWELL-1)) begin
`ifdef TDM_MUX_SKIP_MASK_EN
                    scan_ch = first_set(wrap_inc(ptr), ch_mask);
`else
                    scan_ch = wrap_inc(ptr);
`endif
                    dwell_n = '0;
                end else begin
                    dwell_n = dwell + CNTW'(1);
                end
                ptr_n   = scan_ch;
                y_n     = pick(din, scan_ch);
                ch_n    = scan_ch;
                valid_n = 1'b1;
`ifdef TDM_MUX_SKIP_MASK_EN
                if (ch_mask == '0) begin
                    ptr_n   = ptr;
                    dwell_n = dwell;
                    y_n     = y;
                    ch_n    = ch_id;
                    valid_n = 1'b0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MANUAL;
            ptr     <= '0;
            dwell   <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            ch_id   <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            dwell   <= dwell_n;
            y       <= y_n;
            y_valid <= valid_n;
            ch_id   <= ch_n;
        end
    end

endmodule

// File: tb/tb_tdm_mux.sv
// Directed self-checking bench for tdm_mux (WIDTH=8, CH=4, DWELL=2).
// Mask scenario runs only when TDM_MUX_SKIP_MASK_EN is defined.
module tb_tdm_mux;

    logic        clk;
    logic        rst_n;
    logic [31:0] din;
    logic [1:0]  sel;
    logic        mode;
    logic        en;
    logic [7:0]  y;
    logic        y_valid;
    logic [1:0]  ch_id;
`ifdef TDM_MUX_SKIP_MASK_EN
    logic [3:0]  ch_mask;
`endif

    int total;
    int bad;

    tdm_mux #(.WIDTH(8), .CH(4), .DWELL(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .sel     (sel),
        .mode    (mode),
        .en      (en),
`ifdef TDM_MUX_SKIP_MASK_EN
        .ch_mask (ch_mask),
`endif
        .y       (y),
        .y_valid (y_valid),
        .ch_id   (ch_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = 2'd0;
        #2;
        total++;
        if ({y_valid, ch_id, y} !== {1'b0, 2'd0, 8'h00}) begin
            bad++;
            $display("FAIL reset_async got v=%b ch=%0d y=%h want v=0 ch=0 y=00", y_valid, ch_id, y);
        end
        en = 1'b1; sel = 2'd2;
        step();
        total++;
        if ({y_valid, ch_id, y} !== {1'b0, 2'd0, 8'h00}) begin
            bad++;
            $display("FAIL reset_hold got v=%b ch=%0d y=%h want v=0 ch=0 y=00", y_valid, ch_id, y);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_manual();
        logic [7:0] exp_y [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        en = 1'b1; mode = 1'b0; sel = 2'd2;
        step();
        total++;
        if ({y_valid, ch_id, y} !== {1'b1, 2'd2, 8'h33}) begin
            bad++;
            $display("FAIL manual_first got v=%b ch=%0d y=%h want v=1 ch=2 y=33", y_valid, ch_id, y);
        end
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            step();
            total++;
            if ({y_valid, ch_id, y} !== {1'b1, 2'(i), exp_y[i]}) begin
                bad++;
                $display("FAIL manual_sweep[%0d] got v=%b ch=%0d y=%h want v=1 ch=%0d y=%h",
                         i, y_valid, ch_id, y, i, exp_y[i]);
            end
        end
    endtask

    task automatic test_scan_wrap();
        logic [1:0] exp_ch [10] = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        logic [7:0] lut [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        mode = 1'b1; sel = 2'd3;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if ({y_valid, ch_id, y} !== {1'b1, exp_ch[i], lut[exp_ch[i]]}) begin
                bad++;
                $display("FAIL scan_wrap[%0d] got v=%b ch=%0d y=%h want v=1 ch=%0d y=%h",
                         i, y_valid, ch_id, y, exp_ch[i], lut[exp_ch[i]]);
            end
        end
    endtask

    task automatic test_enable_freeze();
        logic [1:0] pre_ch [3] = '{2'd0, 2'd0, 2'd1};
        logic [7:0] pre_y [3] = '{8'h11, 8'h11, 8'h22};
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({y_valid, ch_id, y} !== {1'b1, pre_ch[i], pre_y[i]}) begin
                bad++;
                $display("FAIL freeze_pre[%0d] got v=%b ch=%0d y=%h want v=1 ch=%0d y=%h",
                         i, y_valid, ch_id, y, pre_ch[i], pre_y[i]);
            end
        end
        en = 1'b0; mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if ({y_valid, ch_id, y} !== {1'b0, 2'd1, 8'h22}) begin
                bad++;
                $display("FAIL freeze_hold[%0d] got v=%b ch=%0d y=%h want v=0 ch=1 y=22",
                         i, y_valid, ch_id, y);
            end
        end
        en = 1'b1; mode = 1'b1;
        step();
        total++;
        if ({y_valid, ch_id, y} !== {1'b1, 2'd1, 8'h22}) begin
            bad++;
            $display("FAIL freeze_resume0 got v=%b ch=%0d y=%h want v=1 ch=1 y=22", y_valid, ch_id, y);
        end
        step();
        total++;
        if ({y_valid, ch_id, y} !== {1'b1, 2'd2, 8'h33}) begin
            bad++;
            $display("FAIL freeze_resume1 got v=%b ch=%0d y=%h want v=1 ch=2 y=33", y_valid, ch_id, y);
        end
    endtask

    task automatic test_mode_return_reset();
        mode = 1'b0; sel = 2'd0;
        step();
        total++;
        if ({y_valid, ch_id, y} !== {1'b1, 2'd0, 8'h11}) begin
            bad++;
            $display("FAIL mode_return got v=%b ch=%0d y=%h want v=1 ch=0 y=11", y_valid, ch_id, y);
        end
        mode = 1'b1; sel = 2'd1;
        step();
        step();
        total++;
        if ({y_valid, ch_id, y} !== {1'b1, 2'd1, 8'h22}) begin
            bad++;
            $display("FAIL reenter_scan got v=%b ch=%0d y=%h want v=1 ch=1 y=22", y_valid, ch_id, y);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({y_valid, ch_id, y} !== {1'b0, 2'd0, 8'h00}) begin
            bad++;
            $display("FAIL midscan_reset got v=%b ch=%0d y=%h want v=0 ch=0 y=00", y_valid, ch_id, y);
        end
        #1;
        rst_n = 1'b1;
        sel = 2'd2;
        step();
        total++;
        if ({y_valid, ch_id, y} !== {1'b1, 2'd2, 8'h33}) begin
            bad++;
            $display("FAIL post_reset_entry got v=%b ch=%0d y=%h want v=1 ch=2 y=33", y_valid, ch_id, y);
        end
    endtask

    task automatic test_scan_all();
        logic [1:0] exp_ch [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        logic [7:0] lut [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        mode = 1'b0; sel = 2'd0;
        step();
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if ({y_valid, ch_id, y} !== {1'b1, exp_ch[i], lut[exp_ch[i]]}) begin
                bad++;
                $display("FAIL scan_all[%0d] got v=%b ch=%0d y=%h want v=1 ch=%0d y=%h",
                         i, y_valid, ch_id, y, exp_ch[i], lut[exp_ch[i]]);
            end
        end
    endtask

`ifdef TDM_MUX_SKIP_MASK_EN
    task automatic test_mask();
        logic [1:0] exp_ch [6] = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1};
        logic [7:0] lut [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        mode = 1'b0; sel = 2'd0;
        step();
        ch_mask = 4'b1010; mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if ({y_valid, ch_id, y} !== {1'b1, exp_ch[i], lut[exp_ch[i]]}) begin
                bad++;
                $display("FAIL mask_seq[%0d] got v=%b ch=%0d y=%h want v=1 ch=%0d y=%h",
                         i, y_valid, ch_id, y, exp_ch[i], lut[exp_ch[i]]);
            end
        end
        ch_mask = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({y_valid, ch_id, y} !== {1'b0, 2'd1, 8'h22}) begin
                bad++;
                $display("FAIL mask_none[%0d] got v=%b ch=%0d y=%h want v=0 ch=1 y=22",
                         i, y_valid, ch_id, y);
            end
        end
        ch_mask = 4'b1111;
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        din   = {8'h44, 8'h33, 8'h22, 8'h11};
`ifdef TDM_MUX_SKIP_MASK_EN
        ch_mask = 4'b1111;
`endif
        test_reset();
        test_manual();
        test_scan_wrap();
        test_enable_freeze();
        test_mode_return_reset();
        test_scan_all();
`ifdef TDM_MUX_SKIP_MASK_EN
        test_mask();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_mux.md
# tdm_mux

Parametrised, registered N:1 multiplexer with manual and auto-scan (time-division) modes. Generalises the 2:1 dataflow mux to CH channels of WIDTH bits. Adds a registered output, a valid flag, channel tagging and a dwell-timed round-robin scanner. It sits between parallel sensor/data lanes and a single serial consumer.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- CH, 4, number of input channels (≥2)
- DWELL, 4, cycles each channel is held in auto-scan (≥1)
- SELW, $clog2(CH), select/channel-id width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- din  in  CH*WIDTH  packed inputs; channel k = din[k*WIDTH +: WIDTH]
- sel  in  SELW  manual select; also the scan start channel
- mode  in  1  0 = manual, 1 = auto-scan
- en  in  1  capture enable; 0 freezes all state
- ch_mask  in  CH  1 = channel included in scan (only with TDM_MUX_SKIP_MASK_EN)
- y  out  WIDTH  registered selected data
- y_valid  out  1  y was captured on the previous edge
- ch_id  out  SELW  channel index that y came from

## Operation
- FSM states: MANUAL, SCAN. Reset state is MANUAL.
- MANUAL, en=1: y <= din[sel], ch_id <= sel, y_valid <= 1. sel ≥ CH (non-power-of-2 CH): y <= 0, ch_id <= sel, y_valid <= 0.
- MANUAL→SCAN on an edge with mode=1, en=1: ptr <= sel (sel ≥ CH loads 0), dwell <= 0. That edge already captures din[new ptr].
- SCAN, en=1: y <= din[ptr], ch_id <= ptr, y_valid <= 1 every cycle. The dwell counter counts 0..DWELL-1. On the edge where dwell==DWELL-1, ptr advances to the next channel and dwell <= 0. After CH-1 comes 0.
- SCAN→MANUAL on an edge with mode=0, en=1. That same edge performs a manual capture from sel. ptr and dwell are left as they are.
- en=0 in either state: y, ch_id, ptr, dwell and state hold; y_valid <= 0. mode changes are ignored while en=0.
- The data path is pure selection. There is no arithmetic on data.
- Counter width is $clog2(DWELL) with a minimum of 1 bit.

## Timing
- Reset (async assert, sync-safe deassert by the system): y=0, y_valid=0, ch_id=0, ptr=0, dwell=0, state=MANUAL.
- Latency is 1 cycle: din/sel sampled at edge n appear on y/ch_id after edge n.
- In auto-scan each channel occupies exactly DWELL consecutive enabled cycles. A full rotation takes CH*DWELL enabled cycles. Cycles with en=0 do not count.
- A reset asserted mid-scan clears everything immediately. After release the block restarts in MANUAL.
- There is no backpressure. The consumer must accept y when y_valid=1.

## Configuration
- TDM_MUX_SKIP_MASK_EN defined:
  - The ch_mask port exists.
  - When ptr advances, it moves to the next channel with ch_mask=1, searching upward with wrap.
  - On entry to SCAN with a masked start channel, ptr goes to the next unmasked channel at or after sel.
  - If the current ptr becomes masked, it advances at the next dwell expiry.
  - If ch_mask==0 in SCAN: ptr and dwell hold, y holds, y_valid <= 0.
  - MANUAL mode ignores ch_mask.
- Not defined: the ch_mask port is absent and every channel is scanned in order.

## Test plan
Use WIDTH=8, CH=4, DWELL=2, din = {8'h44, 8'h33, 8'h22, 8'h11}.
- Reset then manual: rst_n low → y=0, y_valid=0, ch_id=0. Release, en=1, mode=0, sel=2 → next cycle y=8'h33, ch_id=2, y_valid=1. Sweep sel 0..3 → y = 11, 22, 33, 44.
- Auto-scan wrap: mode=1, sel=3 → ch_id sequence 3,3,0,0,1,1,2,2,3,3 with y matching. y_valid is held at 1 throughout.
- Enable freeze: during SCAN at ch_id=1 (first dwell cycle), en=0 for 5 cycles → y and ch_id hold, y_valid=0. With en=1 again → one more cycle on ch 1, then ch 2.
- Mode return and mid-scan reset: from SCAN set mode=0, sel=0 → next y=8'h11. Re-enter SCAN and pulse rst_n low mid-dwell → outputs go to 0 immediately, state is MANUAL.
- Mask (macro on): ch_mask=4'b1010, mode=1, sel=0 → ch_id sequence 1,1,3,3,1,1. With ch_mask=0 → y holds, y_valid=0.
- Macro off: the same bench without ch_mask → all four channels are scanned.
